write_back: RTL and testbench
=============================

Name: write_back

Overview:
- Final pipeline stage. Consumes the execute-to-write stream: result, upper result, flags, memory-store request, flush marker.
- Commits results to the register file, the Flags register and data memory.
- Asserts hold back toward execute while a multi-cycle commit is in progress: two-word result or memory store.

Parameters:
- FLAGS_INDEX, 31, register index of the Flags register.
- REG_INDEX_W, 5, register index width.

Ports:
- clock  in  1  stage clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  execute output holds a valid instruction
- in_hold  out  1  back-pressure to execute; combinational
- in_pc  in  32  pc of the instruction
- in_destination_register  in  5  destination index, or address register when in_is_writing_memory
- in_is_writing_memory  in  1  instruction is a store
- in_flags  in  4  {carry, negative, overflow, zero}
- in_destination_value  in  32  result, or store data
- in_has_upper_value  in  1  upper result must be written to destination+1
- in_upper_value  in  32  upper result (mul high word / div remainder)
- in_adjustment_value  in  32  store address offset
- in_has_flushed  in  1  instruction squashed; commit nothing
- rd_index  out  5  register read index; combinational, equals in_destination_register
- rd_value  in  32  register file data for rd_index, same cycle
- reg_we  out  1  register write enable
- reg_index  out  5  register write index
- reg_value  out  32  register write data
- flags_we  out  1  Flags update enable
- flags_value  out  4  {carry, negative, overflow, zero}; the register file stores these at bits 30,31,29,28
- mem_write  out  1  store request
- mem_address  out  32  store address
- mem_data  out  32  store data
- mem_wait  in  1  memory not ready; store must be held
- retire  out  1  one-cycle pulse per committed instruction
- retire_pc  out  32  pc of the retired instruction

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - state IDLE.
  - All registered outputs 0: reg_we, reg_index, reg_value, flags_we, flags_value, mem_write, mem_address, mem_data, retire, retire_pc.
  - Reset mid-UPPER or mid-MEM abandons the operation; no further writes are issued.
- States: IDLE, UPPER, MEM.
- in_hold = (state != IDLE). Accept = in_valid && state==IDLE.
- All write outputs are registered: one-cycle latency from accept.
- Default each cycle: reg_we=0, flags_we=0, retire=0. mem_write changes only as stated below.
- Accept with in_has_flushed=1: no writes, no retire, stay IDLE.
- Accept, non-store, not flushed:
  - Next cycle: reg_we = (in_destination_register != 0); reg_index = destination; reg_value = in_destination_value.
  - Next cycle: flags_we=1, flags_value=in_flags.
  - If in_has_upper_value=0: retire=1, retire_pc=in_pc; state stays IDLE.
  - If in_has_upper_value=1: go UPPER; latch upper value, index+1 (mod 32) and pc.
- UPPER, one cycle:
  - Next cycle: reg_we = (index+1 != 0), reg_value = upper value, retire=1.
  - Go IDLE.
- Accept, store, not flushed:
  - Next cycle: mem_write=1; mem_address = rd_value + in_adjustment_value (32-bit wrap); mem_data = in_destination_value.
  - No register or flags write. Go MEM.
- MEM:
  - Hold mem_write, mem_address and mem_data stable while mem_wait=1.
  - On a cycle with mem_wait=0: next cycle mem_write=0, retire=1 with the stored pc, go IDLE.
- Destination register 0 is never written; flags are still updated.
- Destination == FLAGS_INDEX with flags_we in the same cycle: the register file gives priority to reg_we. This block drives both unchanged.
- in_valid=0 in IDLE: no action.
- Inputs arriving while in_hold=1 are ignored; execute keeps them stable.

Test Plan:
- ALU result: accept dest=3, value=0x12345678, flags=4'b0001 -> next cycle reg_we=1, reg_index=3, reg_value=0x12345678, flags_we=1, flags_value=0001, retire=1, in_hold stays 0.
- Two-word result: dest=31, value=0xA, upper=0xB, has_upper=1 -> cycle1 reg_we=1 idx31 value 0xA, in_hold=1; cycle2 index wraps to 0 so reg_we=0, retire=1; repeat with dest=4 -> cycle2 writes idx5=0xB.
- Store with wait: rd_value=0x1000, adjustment=0x10, data=0xDEAD, mem_wait high 3 cycles -> mem_write=1 addr 0x1010 data 0xDEAD held stable; in_hold=1 throughout; retire exactly once after mem_wait falls.
- Flushed instruction: has_flushed=1, dest=7 -> no reg_we, flags_we, mem_write or retire.
- Dest 0: dest=0, value=5 -> reg_we=0, flags_we=1, retire=1.
- Reset in MEM with mem_wait=1 -> next cycle mem_write=0, in_hold=0, state IDLE, no retire.

Source files
------------

// File: rtl/write_back.sv
// Final pipeline stage: commits execute results to the register file, the Flags register
// and data memory. Two-word results and stores take extra cycles and hold execute back.
module write_back #(
  parameter int unsigned FLAGS_INDEX = 31,
  parameter int unsigned REG_INDEX_W = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_hold,
  input  logic [31:0]            in_pc,
  input  logic [REG_INDEX_W-1:0] in_destination_register,
  input  logic                   in_is_writing_memory,
  input  logic [3:0]             in_flags,
  input  logic [31:0]            in_destination_value,
  input  logic                   in_has_upper_value,
  input  logic [31:0]            in_upper_value,
  input  logic [31:0]            in_adjustment_value,
  input  logic                   in_has_flushed,
  output logic [REG_INDEX_W-1:0] rd_index,
  input  logic [31:0]            rd_value,
  output logic                   reg_we,
  output logic [REG_INDEX_W-1:0] reg_index,
  output logic [31:0]            reg_value,
  output logic                   flags_we,
  output logic [3:0]             flags_value,
  output logic                   mem_write,
  output logic [31:0]            mem_address,
  output logic [31:0]            mem_data,
  input  logic                   mem_wait,
  output logic                   retire,
  output logic [31:0]            retire_pc
);

  // The register file resolves a same-cycle reg_we/flags_we collision on FLAGS_INDEX itself.
  if (FLAGS_INDEX >= (1 << REG_INDEX_W)) begin : g_flags_index_range
    $error("FLAGS_INDEX does not fit in REG_INDEX_W bits");
  end

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StUpper = 2'd1;
  localparam logic [1:0] StMem   = 2'd2;

  logic [1:0]             state_q, state_d;
  logic                   reg_we_q, reg_we_d;
  logic [REG_INDEX_W-1:0] reg_index_q, reg_index_d;
  logic [31:0]            reg_value_q, reg_value_d;
  logic                   flags_we_q, flags_we_d;
  logic [3:0]             flags_value_q, flags_value_d;
  logic                   mem_write_q, mem_write_d;
  logic [31:0]            mem_address_q, mem_address_d;
  logic [31:0]            mem_data_q, mem_data_d;
  logic                   retire_q, retire_d;
  logic [31:0]            retire_pc_q, retire_pc_d;
  logic [31:0]            upper_value_q, upper_value_d;
  logic [REG_INDEX_W-1:0] upper_index_q, upper_index_d;
  logic [31:0]            pc_q, pc_d;

  assign in_hold  = (state_q != StIdle);
  assign rd_index = in_destination_register;

  always_comb begin
    state_d       = state_q;
    reg_we_d      = 1'b0;
    reg_index_d   = reg_index_q;
    reg_value_d   = reg_value_q;
    flags_we_d    = 1'b0;
    flags_value_d = flags_value_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    retire_d      = 1'b0;
    retire_pc_d   = retire_pc_q;
    upper_value_d = upper_value_q;
    upper_index_d = upper_index_q;
    pc_d          = pc_q;

    case (state_q)
      StIdle: begin
        if (in_valid && !in_has_flushed) begin
          if (in_is_writing_memory) begin
            mem_write_d   = 1'b1;
            mem_address_d = rd_value + in_adjustment_value;
            mem_data_d    = in_destination_value;
            pc_d          = in_pc;
            state_d       = StMem;
          end else begin
            reg_we_d      = (in_destination_register != '0);
            reg_index_d   = in_destination_register;
            reg_value_d   = in_destination_value;
            flags_we_d    = 1'b1;
            flags_value_d = in_flags;
            if (in_has_upper_value) begin
              upper_value_d = in_upper_value;
              upper_index_d = in_destination_register + 1'b1;
              pc_d          = in_pc;
              state_d       = StUpper;
            end else begin
              retire_d    = 1'b1;
              retire_pc_d = in_pc;
            end
          end
        end
      end
      StUpper: begin
        reg_we_d    = (upper_index_q != '0);
        reg_index_d = upper_index_q;
        reg_value_d = upper_value_q;
        retire_d    = 1'b1;
        retire_pc_d = pc_q;
        state_d     = StIdle;
      end
      StMem: begin
        // Request stays asserted and stable until memory stops waiting.
        if (!mem_wait) begin
          mem_write_d = 1'b0;
          retire_d    = 1'b1;
          retire_pc_d = pc_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      reg_we_q      <= 1'b0;
      reg_index_q   <= '0;
      reg_value_q   <= '0;
      flags_we_q    <= 1'b0;
      flags_value_q <= '0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      retire_q      <= 1'b0;
      retire_pc_q   <= '0;
      upper_value_q <= '0;
      upper_index_q <= '0;
      pc_q          <= '0;
    end else begin
      state_q       <= state_d;
      reg_we_q      <= reg_we_d;
      reg_index_q   <= reg_index_d;
      reg_value_q   <= reg_value_d;
      flags_we_q    <= flags_we_d;
      flags_value_q <= flags_value_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      retire_q      <= retire_d;
      retire_pc_q   <= retire_pc_d;
      upper_value_q <= upper_value_d;
      upper_index_q <= upper_index_d;
      pc_q          <= pc_d;
    end
  end

  assign reg_we      = reg_we_q;
  assign reg_index   = reg_index_q;
  assign reg_value   = reg_value_q;
  assign flags_we    = flags_we_q;
  assign flags_value = flags_value_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign retire      = retire_q;
  assign retire_pc   = retire_pc_q;

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: ALU, two-word, store, flush, dest-0 and reset-in-MEM cases.
module tb_write_back;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_hold;
  logic [31:0] in_pc;
  logic [4:0]  in_destination_register;
  logic        in_is_writing_memory;
  logic [3:0]  in_flags;
  logic [31:0] in_destination_value;
  logic        in_has_upper_value;
  logic [31:0] in_upper_value;
  logic [31:0] in_adjustment_value;
  logic        in_has_flushed;
  logic [4:0]  rd_index;
  logic [31:0] rd_value;
  logic        reg_we;
  logic [4:0]  reg_index;
  logic [31:0] reg_value;
  logic        flags_we;
  logic [3:0]  flags_value;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_wait;
  logic        retire;
  logic [31:0] retire_pc;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  write_back dut (
    .clock                  (clock),
    .reset                  (reset),
    .in_valid               (in_valid),
    .in_hold                (in_hold),
    .in_pc                  (in_pc),
    .in_destination_register(in_destination_register),
    .in_is_writing_memory   (in_is_writing_memory),
    .in_flags               (in_flags),
    .in_destination_value   (in_destination_value),
    .in_has_upper_value     (in_has_upper_value),
    .in_upper_value         (in_upper_value),
    .in_adjustment_value    (in_adjustment_value),
    .in_has_flushed         (in_has_flushed),
    .rd_index               (rd_index),
    .rd_value               (rd_value),
    .reg_we                 (reg_we),
    .reg_index              (reg_index),
    .reg_value              (reg_value),
    .flags_we               (flags_we),
    .flags_value            (flags_value),
    .mem_write              (mem_write),
    .mem_address            (mem_address),
    .mem_data               (mem_data),
    .mem_wait               (mem_wait),
    .retire                 (retire),
    .retire_pc              (retire_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid                = 1'b0;
    in_pc                   = '0;
    in_destination_register = '0;
    in_is_writing_memory    = 1'b0;
    in_flags                = '0;
    in_destination_value    = '0;
    in_has_upper_value      = 1'b0;
    in_upper_value          = '0;
    in_adjustment_value     = '0;
    in_has_flushed          = 1'b0;
    rd_value                = '0;
    mem_wait                = 1'b0;
  endtask

  task automatic alu(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] val,
                     input logic [3:0] flags, input logic has_upper, input logic [31:0] upper);
    clear_inputs();
    in_valid                = 1'b1;
    in_pc                   = pc;
    in_destination_register = dest;
    in_destination_value    = val;
    in_flags                = flags;
    in_has_upper_value      = has_upper;
    in_upper_value          = upper;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    check("rst_reg_we", {31'd0, reg_we}, 32'd0);
    check("rst_flags_we", {31'd0, flags_we}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_retire", {31'd0, retire}, 32'd0);
    check("rst_retire_pc", retire_pc, 32'd0);
    check("rst_in_hold", {31'd0, in_hold}, 32'd0);
    reset = 1'b0;

    // Idle with no valid input: nothing happens
    step();
    check("idle_retire", {31'd0, retire}, 32'd0);
    check("idle_reg_we", {31'd0, reg_we}, 32'd0);

    // Plain ALU result
    alu(32'h100, 5'd3, 32'h1234_5678, 4'b0001, 1'b0, 32'd0);
    #1;
    check("alu_rd_index", {27'd0, rd_index}, 32'd3);
    step();
    in_valid = 1'b0;
    check("alu_reg_we", {31'd0, reg_we}, 32'd1);
    check("alu_reg_index", {27'd0, reg_index}, 32'd3);
    check("alu_reg_value", reg_value, 32'h1234_5678);
    check("alu_flags_we", {31'd0, flags_we}, 32'd1);
    check("alu_flags_value", {28'd0, flags_value}, 32'd1);
    check("alu_retire", {31'd0, retire}, 32'd1);
    check("alu_retire_pc", retire_pc, 32'h100);
    check("alu_in_hold", {31'd0, in_hold}, 32'd0);
    step();
    check("alu_retire_pulse", {31'd0, retire}, 32'd0);
    check("alu_reg_we_pulse", {31'd0, reg_we}, 32'd0);

    // Two-word result into r31: upper index wraps to 0 and is suppressed
    alu(32'h200, 5'd31, 32'hA, 4'b1000, 1'b1, 32'hB);
    step();
    check("up31_c1_reg_we", {31'd0, reg_we}, 32'd1);
    check("up31_c1_reg_index", {27'd0, reg_index}, 32'd31);
    check("up31_c1_reg_value", reg_value, 32'hA);
    check("up31_c1_in_hold", {31'd0, in_hold}, 32'd1);
    check("up31_c1_retire", {31'd0, retire}, 32'd0);
    step();
    in_valid = 1'b0;
    check("up31_c2_reg_we", {31'd0, reg_we}, 32'd0);
    check("up31_c2_retire", {31'd0, retire}, 32'd1);
    check("up31_c2_retire_pc", retire_pc, 32'h200);
    check("up31_c2_in_hold", {31'd0, in_hold}, 32'd0);
    check("up31_c2_flags_we", {31'd0, flags_we}, 32'd0);

    // Two-word result into r4: upper word lands in r5
    alu(32'h204, 5'd4, 32'hA, 4'b0100, 1'b1, 32'hB);
    step();
    check("up4_c1_reg_index", {27'd0, reg_index}, 32'd4);
    check("up4_c1_retire", {31'd0, retire}, 32'd0);
    step();
    in_valid = 1'b0;
    check("up4_c2_reg_we", {31'd0, reg_we}, 32'd1);
    check("up4_c2_reg_index", {27'd0, reg_index}, 32'd5);
    check("up4_c2_reg_value", reg_value, 32'hB);
    check("up4_c2_retire", {31'd0, retire}, 32'd1);
    check("up4_c2_retire_pc", retire_pc, 32'h204);

    // Store with memory wait
    clear_inputs();
    in_valid                = 1'b1;
    in_pc                   = 32'h300;
    in_destination_register = 5'd2;
    in_is_writing_memory    = 1'b1;
    in_destination_value    = 32'hDEAD;
    in_adjustment_value     = 32'h10;
    rd_value                = 32'h1000;
    mem_wait                = 1'b1;
    step();
    check("st_mem_write", {31'd0, mem_write}, 32'd1);
    check("st_mem_address", mem_address, 32'h1010);
    check("st_mem_data", mem_data, 32'hDEAD);
    check("st_reg_we", {31'd0, reg_we}, 32'd0);
    check("st_flags_we", {31'd0, flags_we}, 32'd0);
    check("st_in_hold", {31'd0, in_hold}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_wait_mem_write", {31'd0, mem_write}, 32'd1);
      check("st_wait_mem_address", mem_address, 32'h1010);
      check("st_wait_mem_data", mem_data, 32'hDEAD);
      check("st_wait_in_hold", {31'd0, in_hold}, 32'd1);
      check("st_wait_retire", {31'd0, retire}, 32'd0);
    end
    mem_wait = 1'b0;
    in_valid = 1'b0;
    step();
    check("st_done_mem_write", {31'd0, mem_write}, 32'd0);
    check("st_done_retire", {31'd0, retire}, 32'd1);
    check("st_done_retire_pc", retire_pc, 32'h300);
    check("st_done_in_hold", {31'd0, in_hold}, 32'd0);
    step();
    check("st_retire_once", {31'd0, retire}, 32'd0);

    // Flushed instruction commits nothing
    alu(32'h400, 5'd7, 32'h77, 4'b1111, 1'b0, 32'd0);
    in_has_flushed = 1'b1;
    step();
    in_valid = 1'b0;
    check("fl_reg_we", {31'd0, reg_we}, 32'd0);
    check("fl_flags_we", {31'd0, flags_we}, 32'd0);
    check("fl_mem_write", {31'd0, mem_write}, 32'd0);
    check("fl_retire", {31'd0, retire}, 32'd0);
    check("fl_in_hold", {31'd0, in_hold}, 32'd0);

    // Destination r0: no register write, flags still updated
    alu(32'h500, 5'd0, 32'd5, 4'b0010, 1'b0, 32'd0);
    step();
    in_valid = 1'b0;
    check("r0_reg_we", {31'd0, reg_we}, 32'd0);
    check("r0_flags_we", {31'd0, flags_we}, 32'd1);
    check("r0_flags_value", {28'd0, flags_value}, 32'd2);
    check("r0_retire", {31'd0, retire}, 32'd1);
    check("r0_retire_pc", retire_pc, 32'h500);

    // Reset while a store is waiting
    clear_inputs();
    in_valid             = 1'b1;
    in_pc                = 32'h600;
    in_is_writing_memory = 1'b1;
    in_destination_value = 32'hBEEF;
    rd_value             = 32'h2000;
    in_adjustment_value  = 32'hFFFF_FFFC;
    mem_wait             = 1'b1;
    step();
    check("rm_mem_write", {31'd0, mem_write}, 32'd1);
    check("rm_mem_address_wrap", mem_address, 32'h1FFC);
    reset    = 1'b1;
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    check("rm_mem_write_cleared", {31'd0, mem_write}, 32'd0);
    check("rm_mem_address", mem_address, 32'd0);
    check("rm_in_hold", {31'd0, in_hold}, 32'd0);
    check("rm_retire", {31'd0, retire}, 32'd0);
    step();
    check("rm_post_retire", {31'd0, retire}, 32'd0);
    check("rm_post_mem_write", {31'd0, mem_write}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
